spwm_gate_driver: RTL

- Downstream consumer of the carrier ramp generator.
- Compares the 15-bit carrier sample against a regularly-sampled modulation reference to form the SPWM comparison.
- Turns that comparison into a complementary high-side/low-side gate pair with programmable dead time.
- Feeds the power stage; the upstream ramp generator updates its output once every few clocks and signals each update with a strobe.

---
 rtl/spwm_pkg.sv | 21 ++
 rtl/spwm_deadtime.sv | 82 ++++++++
 rtl/spwm_gate_driver.sv | 66 ++++++
 3 files changed

// File: rtl/spwm_pkg.sv
// ---------------------------------------------------------------------------
// spwm_pkg : constants and FSM encoding shared with the carrier ramp generator
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spwm_pkg;

  localparam int WIDTH       = 15;
  localparam int CARRIER_MAX = 15358;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DT   = 2'd1,
    ST_H_ON = 2'd2,
    ST_L_ON = 2'd3
  } dt_state_t;

endpackage

`default_nettype wire

// File: rtl/spwm_deadtime.sv
// ---------------------------------------------------------------------------
// spwm_deadtime : complementary gate FSM with programmable dead time
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spwm_deadtime #(
  parameter int DEAD_CYCLES = 32,
  parameter int DT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic cmp,
  output logic gate_h,
  output logic gate_l,
  output logic dt_active
);

  import spwm_pkg::*;

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_CYCLES - 1);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  dt_state_t       state;
  dt_state_t       state_nxt;
  logic [DT_W-1:0] cnt;
  logic [DT_W-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_DT;
          cnt_nxt   = DT_LOAD;
        end
        // Only the comparison seen at the end of the interval matters.
        ST_DT: begin
          if (cnt == '0) state_nxt = cmp ? ST_H_ON : ST_L_ON;
          else           cnt_nxt   = cnt - DT_ONE;
        end
        ST_H_ON: begin
          if (!cmp) begin
            state_nxt = ST_DT;
            cnt_nxt   = DT_LOAD;
          end
        end
        ST_L_ON: begin
          if (cmp) begin
            state_nxt = ST_DT;
            cnt_nxt   = DT_LOAD;
          end
        end
      endcase
    end
  end

  // Gates decode the next state so both can never be high in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      cnt       <= '0;
      gate_h    <= 1'b0;
      gate_l    <= 1'b0;
      dt_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gate_h    <= (state_nxt == ST_H_ON);
      gate_l    <= (state_nxt == ST_L_ON);
      dt_active <= (state_nxt == ST_DT);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spwm_gate_driver.sv
// ---------------------------------------------------------------------------
// spwm_gate_driver : regularly-sampled SPWM comparator driving a dead-time gate pair
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spwm_gate_driver #(
  parameter int WIDTH       = spwm_pkg::WIDTH,
  parameter int CARRIER_MAX = spwm_pkg::CARRIER_MAX,
  parameter int DEAD_CYCLES = 32,
  parameter int DT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] carrier,
  input  logic             carrier_vld,
  input  logic [WIDTH-1:0] mod_ref,
  output logic [WIDTH-1:0] ref_q,
  output logic             cmp,
  output logic             gate_h,
  output logic             gate_l,
  output logic             dt_active
);

  import spwm_pkg::*;

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(CARRIER_MAX);

  logic             armed;
  logic             sample;
  logic [WIDTH-1:0] cmp_ref;

  // armed marks that no strobe has been seen since the driver was enabled.
  assign sample  = carrier_vld & ((carrier == '0) | (carrier == C_MAX) | (en & armed));
  assign cmp_ref = sample ? mod_ref : ref_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      cmp   <= 1'b0;
      armed <= 1'b1;
    end else begin
      if (sample)      ref_q <= mod_ref;
      if (carrier_vld) cmp   <= (cmp_ref > carrier);
      if (!en)              armed <= 1'b1;
      else if (carrier_vld) armed <= 1'b0;
    end
  end

  spwm_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES),
    .DT_W        (DT_W)
  ) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmp       (cmp),
    .gate_h    (gate_h),
    .gate_l    (gate_l),
    .dt_active (dt_active)
  );

endmodule

`default_nettype wire
